stream_parity_acc: RTL and testbench

- Parametrised, sequential successor to the team's fixed 5-input XOR parity cone.
- Accepts a stream of WIDTH-bit beats over a valid/ready handshake and XOR-reduces every beat of a frame (terminated by in_last) into one parity bit.
- Checks that bit against an expected value and presents the result, error flag and beat count on a registered result port with its own valid/ready handshake.
- Sits between a packet source and the downstream integrity/status logic.

---
 rtl/stream_parity_acc.sv | 136 +++++++++++++
 tb/tb_stream_parity_acc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stream_parity_acc.sv
// Streaming frame parity accumulator: XOR-reduces every beat of a frame into one parity bit
// and presents parity, mismatch flag and saturating beat count on a held result port.
module stream_parity_acc #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_exp,
  input  logic             odd_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_parity,
  output logic             res_err,
  output logic [CNT_W-1:0] res_beats,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic               acc_reg, acc_next;
  logic               mode_reg, mode_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               busy_reg, busy_next;
  logic               res_valid_reg, res_valid_next;
  logic               res_parity_reg, res_parity_next;
  logic               res_err_reg, res_err_next;
  logic [CNT_W-1:0]   res_beats_reg, res_beats_next;

  logic [WIDTH-1:0]   xor_chain;
  logic               bp;
  logic               accept;
  logic               produce;
  logic               in_accum;
  logic               acc_eff;
  logic               mode_eff;
  logic [CNT_W-1:0]   count_eff;
  logic [CNT_W-1:0]   count_inc;
  logic               frame_parity;

  // Beat parity as a prefix-XOR chain over the payload bits
  assign xor_chain[0] = in_data[0];
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_xor
      assign xor_chain[gi] = xor_chain[gi-1] ^ in_data[gi];
    end
  endgenerate
  assign bp = xor_chain[WIDTH-1];

  assign in_ready = ~res_valid_reg | res_ready;
  assign accept   = in_valid & in_ready;
  assign produce  = accept & in_last;
  assign in_accum = (state_reg == ACCUM);

  // In IDLE the current beat opens the frame, so history is empty and the live mode applies
  assign acc_eff      = in_accum ? acc_reg   : 1'b0;
  assign mode_eff     = in_accum ? mode_reg  : odd_mode;
  assign count_eff    = in_accum ? count_reg : '0;
  assign count_inc    = (count_eff == {CNT_W{1'b1}}) ? count_eff : count_eff + CNT_W'(1);
  assign frame_parity = acc_eff ^ bp ^ mode_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && !in_last) state_next = ACCUM;
      ACCUM:   if (produce)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next        = acc_reg;
    mode_next       = mode_reg;
    count_next      = count_reg;
    busy_next       = busy_reg;
    res_parity_next = res_parity_reg;
    res_err_next    = res_err_reg;
    res_beats_next  = res_beats_reg;
    res_valid_next  = res_ready ? 1'b0 : res_valid_reg;
    if (accept && !in_last) begin
      acc_next   = acc_eff ^ bp;
      count_next = count_inc;
      busy_next  = 1'b1;
      if (!in_accum) mode_next = odd_mode;
    end
    if (produce) begin
      res_parity_next = frame_parity;
      res_err_next    = frame_parity ^ in_exp;
      res_beats_next  = count_inc;
      res_valid_next  = 1'b1;
      busy_next       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg        <= 1'b0;
      mode_reg       <= 1'b0;
      count_reg      <= '0;
      busy_reg       <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_parity_reg <= 1'b0;
      res_err_reg    <= 1'b0;
      res_beats_reg  <= '0;
    end else begin
      acc_reg        <= acc_next;
      mode_reg       <= mode_next;
      count_reg      <= count_next;
      busy_reg       <= busy_next;
      res_valid_reg  <= res_valid_next;
      res_parity_reg <= res_parity_next;
      res_err_reg    <= res_err_next;
      res_beats_reg  <= res_beats_next;
    end
  end

  assign res_valid  = res_valid_reg;
  assign res_parity = res_parity_reg;
  assign res_err    = res_err_reg;
  assign res_beats  = res_beats_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_stream_parity_acc.sv
// Bench for stream_parity_acc: two instances (8-bit and 2-bit beat counters) share one stimulus
// and are checked every cycle against a frame-level model plus hand-computed literals.
module tb_stream_parity_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_exp = 1'b0;
  logic       odd_mode = 1'b0;
  logic       res_ready = 1'b1;

  logic       in_ready8, res_valid8, res_parity8, res_err8, busy8;
  logic [7:0] res_beats8;
  logic       in_ready2, res_valid2, res_parity2, res_err2, busy2;
  logic [1:0] res_beats2;

  int vectors = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Model: frame-level bookkeeping (beats seen, ones seen, frame mode)
  bit m_valid, m_par, m_err, m_mode;
  int m_cnt, m_ones, m_beats;

  always #5 clk = ~clk;

  stream_parity_acc #(.WIDTH(5), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .in_last(in_last), .in_exp(in_exp), .odd_mode(odd_mode), .res_valid(res_valid8),
    .res_ready(res_ready), .res_parity(res_parity8), .res_err(res_err8),
    .res_beats(res_beats8), .busy(busy8)
  );

  stream_parity_acc #(.WIDTH(5), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .in_exp(in_exp), .odd_mode(odd_mode), .res_valid(res_valid2),
    .res_ready(res_ready), .res_parity(res_parity2), .res_err(res_err2),
    .res_beats(res_beats2), .busy(busy2)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int  ones;
    bit  p;
    if (rst) begin
      m_valid <= 1'b0; m_par <= 1'b0; m_err <= 1'b0; m_mode <= 1'b0;
      m_cnt <= 0; m_ones <= 0; m_beats <= 0;
    end else begin
      if (res_ready) m_valid <= 1'b0;
      if (in_valid && (!m_valid || res_ready)) begin
        ones = $countones(in_data);
        if (in_last) begin
          p = (((m_ones + ones) % 2) == 1) ^ ((m_cnt == 0) ? odd_mode : m_mode);
          m_valid <= 1'b1; m_par <= p; m_err <= p ^ in_exp; m_beats <= m_cnt + 1;
          m_cnt <= 0; m_ones <= 0;
        end else begin
          if (m_cnt == 0) m_mode <= odd_mode;
          m_cnt <= m_cnt + 1; m_ones <= m_ones + ones;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", int'(in_ready8), int'(!m_valid || res_ready));
      chk("in_ready2", int'(in_ready2), int'(!m_valid || res_ready));
      chk("res_valid", int'(res_valid8), int'(m_valid));
      chk("res_valid2", int'(res_valid2), int'(m_valid));
      chk("busy", int'(busy8), int'(m_cnt > 0));
      chk("busy2", int'(busy2), int'(m_cnt > 0));
      if (m_valid) begin
        chk("res_parity", int'(res_parity8), int'(m_par));
        chk("res_err", int'(res_err8), int'(m_err));
        chk("res_beats", int'(res_beats8), (m_beats > 255) ? 255 : m_beats);
        chk("res_parity2", int'(res_parity2), int'(m_par));
        chk("res_beats2", int'(res_beats2), (m_beats > 3) ? 3 : m_beats);
      end
      $display("cyc t=%0t v=%0b d=%h l=%0b rr=%0b | rv=%0b p=%0b e=%0b n=%0d/%0d busy=%0b",
               $time, in_valid, in_data, in_last, res_ready, res_valid8, res_parity8,
               res_err8, res_beats8, res_beats2, busy8);
    end
  end

  // Apply inputs just after a falling edge and hold them across the next rising edge
  task automatic drive(input bit v, input logic [4:0] d, input bit l, input bit e,
                       input bit m, input bit rr);
    in_valid = v; in_data = d; in_last = l; in_exp = e; odd_mode = m; res_ready = rr;
    @(negedge clk); #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    checking = 1'b1;
    chk("idle_in_ready", int'(in_ready8), 1);
    chk("idle_res_valid", int'(res_valid8), 0);
    chk("idle_busy", int'(busy8), 0);

    // Single beat 10110, even, exp=1, held result for back-pressure
    drive(1, 5'b10110, 1, 1, 0, 0);
    chk("single_valid", int'(res_valid8), 1);
    chk("single_parity", int'(res_parity8), 1);
    chk("single_err", int'(res_err8), 0);
    chk("single_beats", int'(res_beats8), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'h0A, 1, 0, 0, 0);
      chk("bp_in_ready", int'(in_ready8), 0);
      chk("bp_parity_hold", int'(res_parity8), 1);
      chk("bp_beats_hold", int'(res_beats8), 1);
    end
    drive(1, 5'h03, 1, 0, 0, 1);
    chk("bp_next_valid", int'(res_valid8), 1);
    chk("bp_next_parity", int'(res_parity8), 0);
    chk("bp_next_err", int'(res_err8), 0);

    // Three-beat odd frame with mode toggle and an invalid-last bubble
    drive(1, 5'h1F, 0, 1, 1, 1);
    chk("f3_busy", int'(busy8), 1);
    drive(0, 5'h1F, 1, 1, 0, 1);
    drive(1, 5'h03, 0, 1, 0, 1);
    drive(1, 5'h01, 1, 0, 0, 1);
    chk("f3_parity", int'(res_parity8), 1);
    chk("f3_err", int'(res_err8), 1);
    chk("f3_beats", int'(res_beats8), 3);
    chk("f3_busy_done", int'(busy8), 0);
    drive(0, 5'h00, 0, 0, 0, 1);
    chk("f3_consumed", int'(res_valid8), 0);

    // Six-beat frame: 12 ones -> even parity; 2-bit counter saturates at 3
    drive(1, 5'h1F, 0, 0, 0, 1);
    drive(1, 5'h01, 0, 0, 1, 1);
    drive(1, 5'h00, 0, 0, 1, 1);
    drive(1, 5'h07, 0, 0, 0, 1);
    drive(1, 5'h02, 0, 0, 1, 1);
    drive(1, 5'h03, 1, 1, 1, 1);
    chk("sat_parity", int'(res_parity8), 0);
    chk("sat_err", int'(res_err8), 1);
    chk("sat_beats8", int'(res_beats8), 6);
    chk("sat_beats2", int'(res_beats2), 3);
    chk("sat_parity2", int'(res_parity2), 0);

    // Reset mid-frame with a result still pending
    drive(1, 5'h07, 0, 0, 1, 0);
    drive(1, 5'h01, 0, 0, 1, 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_valid", int'(res_valid8), 0);
    chk("rst_beats", int'(res_beats8), 0);
    drive(0, 5'h00, 0, 0, 0, 1);
    rst = 1'b0;
    drive(1, 5'h01, 1, 1, 0, 1);
    chk("post_rst_parity", int'(res_parity8), 1);
    chk("post_rst_err", int'(res_err8), 0);
    chk("post_rst_beats", int'(res_beats8), 1);

    // Randomised traffic, checked by the model alone
    for (int i = 0; i < 60; i++) begin
      drive(bit'($urandom_range(0, 1)), 5'($urandom), ($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0));
    end
    drive(0, 5'h00, 0, 0, 0, 1);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
